ex_div_stage: RTL and testbench
===============================

Name: ex_div_stage

Overview:
- EX-side consumer of the ID→EX handshake: samples the decode payload when `ctl_id_over_i && ctl_ex_allow_in_o`, executes, and presents a registered result to MEM with its own over/allow_in pair.
- Non-divide ops (ALU result precomputed by ID) pass through in 1 cycle.
- Divide/modulo ops run on an iterative radix-2 restoring divider (32 cycles) that back-pressures ID via `ctl_ex_allow_in_o`.

Parameters:
- `DIV_ITERS`, 32, divider iterations; must equal the operand width (32).

Ports:
- `clk_i`  in  1  clock, rising edge
- `rst_n_i`  in  1  reset, asynchronous, active-low
- `ctl_id_over_i`  in  1  ID has a valid instruction on the `id_*` inputs
- `ctl_ex_allow_in_o`  out  1  EX can accept this cycle
- `id_pc_i`  in  32  instruction PC
- `id_alu_res_i`  in  32  result for non-divide ops
- `id_src1_i`  in  32  dividend
- `id_src2_i`  in  32  divisor
- `id_is_div_i`  in  1  1 = divider op, 0 = pass-through
- `id_div_op_i`  in  2  00 DIV signed, 01 DIVU, 10 MOD signed, 11 MODU
- `id_rd_i`  in  5  destination register
- `id_rf_we_i`  in  1  register-file write enable
- `ctl_mem_allow_in_i`  in  1  MEM can accept this cycle
- `ctl_ex_over_o`  out  1  EX result valid for MEM
- `ex_pc_o`  out  32  registered PC
- `ex_result_o`  out  32  result
- `ex_rd_o`  out  5  registered rd
- `ex_rf_we_o`  out  1  registered write enable
- `ex_busy_o`  out  1  divider iterating

Behaviour:

States:
- IDLE: empty.
- CALC: iterating.
- DONE: holding a valid result.

Control signals:
- `accept = ctl_id_over_i && ctl_ex_allow_in_o`.
- `ctl_ex_allow_in_o = (state==IDLE) || (state==DONE && ctl_mem_allow_in_i)`. Combinational; low throughout CALC.
- `ctl_ex_over_o = (state==DONE)`.
- `ex_busy_o = (state==CALC)`.

Reset (`rst_n_i` low, asynchronous, any state including mid-CALC):
- state = IDLE, iteration counter = 0, divider registers = 0.
- All outputs 0: `ex_pc_o`, `ex_result_o`, `ex_rd_o`, `ex_rf_we_o`, `ctl_ex_over_o`, `ex_busy_o` = 0.
- `ctl_ex_allow_in_o` = 1 once in IDLE.
- An aborted division produces no output.

On `accept`:
- `ex_pc_o`, `ex_rd_o` and `ex_rf_we_o` are loaded on the accept edge and held until the next accept.
- Pass-through (`id_is_div_i=0`): `ex_result_o <= id_alu_res_i`, next state DONE. `ctl_ex_over_o` is high in the cycle after the accept edge (latency 1).
- Divide, `id_src2_i == 0`:
  - No iteration; next state DONE.
  - DIV/DIVU: `ex_result_o = 32'hFFFF_FFFF`.
  - MOD/MODU: `ex_result_o = id_src1_i`.
- Divide, nonzero divisor:
  - Latch |src1| and |src2|. Take absolute values for signed ops; unsigned ops use the raw values.
  - Latch quotient sign = `s1^s2`, remainder sign = `s1`; both 0 for unsigned ops.
  - Clear the remainder register, counter = 0, next state CALC.

CALC:
- Each edge performs one restoring step: shift {rem, quo} left 1, trial-subtract the divisor, set quotient LSB; counter++.
- After the edge where the counter reaches `DIV_ITERS` (32nd iteration edge), the final sign-corrected quotient or remainder is written to `ex_result_o` and the next state is DONE.
- `ctl_ex_over_o` is therefore first high 33 cycles after the accept edge.
- Sign correction: two's-complement negate the quotient if its sign is 1; negate the remainder if its sign is 1.
- -2^31 / -1 (DIV) yields 32'h8000_0000; MOD yields 0. This falls out of the 32-bit unsigned magnitude path and needs no special case.

DONE:
- If `ctl_mem_allow_in_i`=1: the result is consumed this edge.
  - If `accept` is also true, the new instruction is loaded the same edge (back-to-back, no bubble).
  - Otherwise next state is IDLE.
- If `ctl_mem_allow_in_i`=0: all `ex_*` outputs hold and `ctl_ex_allow_in_o`=0.

Other rules:
- `id_*` inputs are ignored while not accepting. ID changing operands mid-CALC has no effect.
- `id_div_op_i` is ignored when `id_is_div_i`=0.

Test Plan:
1. Pass-through: reset, then `id_over`=1, `alu_res`=32'h1234_5678, `pc`=32'h1C00_0000, `rd`=5, `we`=1, `mem_allow`=1 → `ex_over`=1 next cycle with those values. Streaming 4 back-to-back ops, `allow_in` stays 1 and there are no bubbles.
2. DIV signed: `src1`=-7 (32'hFFFF_FFF9), `src2`=2 → `allow_in`=0 for 32 cycles, `busy`=1. `ex_result`=32'hFFFF_FFFD (-3) with `ex_over` first high 33 cycles after accept. MOD on the same operands = 32'hFFFF_FFFF (-1). DIVU 32'hFFFF_FFF9/2 = 32'h7FFF_FFFC.
3. Divide-by-zero: DIVU 100/0 → result 32'hFFFF_FFFF, `ex_over` 1 cycle after accept. MOD 100/0 → 100. Overflow DIV 32'h8000_0000 / 32'hFFFF_FFFF → 32'h8000_0000, MOD → 0.
4. Back-pressure: result in DONE with `mem_allow`=0 for 5 cycles → outputs stable, `allow_in`=0, new `id_over` not accepted. Raise `mem_allow` with `id_over`=1 → new instruction loaded the same edge.
5. Reset mid-CALC: start a DIV, pull `rst_n_i` low at iteration 10 (asynchronously, between edges) → outputs zero immediately, state IDLE, `allow_in`=1 after release. The next pass-through op completes normally and no stale divider result appears.

Source files
------------

// File: rtl/ex_div_stage.sv
// EX stage: registers pass-through ALU results and runs a 32-cycle radix-2
// restoring divider for DIV/DIVU/MOD/MODU, with valid/allow handshakes on both sides.
module ex_div_stage #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ctl_id_over_i,
    output logic        ctl_ex_allow_in_o,
    input  logic [31:0] id_pc_i,
    input  logic [31:0] id_alu_res_i,
    input  logic [31:0] id_src1_i,
    input  logic [31:0] id_src2_i,
    input  logic        id_is_div_i,
    input  logic [1:0]  id_div_op_i,
    input  logic [4:0]  id_rd_i,
    input  logic        id_rf_we_i,
    input  logic        ctl_mem_allow_in_i,
    output logic        ctl_ex_over_o,
    output logic [31:0] ex_pc_o,
    output logic [31:0] ex_result_o,
    output logic [4:0]  ex_rd_o,
    output logic        ex_rf_we_o,
    output logic        ex_busy_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [5:0] LAST_ITER = 6'(DIV_ITERS - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dsr_q, dsr_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        is_mod_q, is_mod_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] res_q, res_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d;

    logic        accept;
    logic        is_signed, sgn1, sgn2;
    logic [31:0] mag1, mag2;
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] rem_step, quo_step, fin_val;

    assign ctl_ex_allow_in_o = (state_q == IDLE) || ((state_q == DONE) && ctl_mem_allow_in_i);
    assign accept            = ctl_id_over_i && ctl_ex_allow_in_o;
    assign ctl_ex_over_o     = (state_q == DONE);
    assign ex_busy_o         = (state_q == CALC);
    assign ex_pc_o           = pc_q;
    assign ex_result_o       = res_q;
    assign ex_rd_o           = rd_q;
    assign ex_rf_we_o        = we_q;

    // Operand magnitudes: the divider core only ever sees unsigned values.
    always_comb begin
        is_signed = !id_div_op_i[0];
        sgn1      = is_signed && id_src1_i[31];
        sgn2      = is_signed && id_src2_i[31];
        mag1      = sgn1 ? -id_src1_i : id_src1_i;
        mag2      = sgn2 ? -id_src2_i : id_src2_i;
    end

    // One restoring step; the shifted remainder needs 33 bits before the trial subtract.
    always_comb begin
        rem_sh   = {rem_q, quo_q[31]};
        fits     = (rem_sh >= {1'b0, dsr_q});
        rem_step = fits ? 32'(rem_sh - {1'b0, dsr_q}) : rem_sh[31:0];
        quo_step = {quo_q[30:0], fits};
        if (is_mod_q) begin
            fin_val = r_neg_q ? -rem_step : rem_step;
        end else begin
            fin_val = q_neg_q ? -quo_step : quo_step;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dsr_d    = dsr_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        is_mod_d = is_mod_q;
        pc_d     = pc_q;
        res_d    = res_q;
        rd_d     = rd_q;
        we_d     = we_q;

        case (state_q)
            CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
                    res_d   = fin_val;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ctl_mem_allow_in_i) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // A same-edge accept from DONE overrides the drop back to IDLE.
        if (accept) begin
            pc_d = id_pc_i;
            rd_d = id_rd_i;
            we_d = id_rf_we_i;
            if (!id_is_div_i) begin
                res_d   = id_alu_res_i;
                state_d = DONE;
            end else if (id_src2_i == 32'd0) begin
                res_d   = id_div_op_i[1] ? id_src1_i : 32'hFFFF_FFFF;
                state_d = DONE;
            end else begin
                rem_d    = 32'd0;
                quo_d    = mag1;
                dsr_d    = mag2;
                q_neg_d  = sgn1 ^ sgn2;
                r_neg_d  = sgn1;
                is_mod_d = id_div_op_i[1];
                cnt_d    = 6'd0;
                state_d  = CALC;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dsr_q    <= 32'd0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            is_mod_q <= 1'b0;
            pc_q     <= 32'd0;
            res_q    <= 32'd0;
            rd_q     <= 5'd0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dsr_q    <= dsr_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            is_mod_q <= is_mod_d;
            pc_q     <= pc_d;
            res_q    <= res_d;
            rd_q     <= rd_d;
            we_q     <= we_d;
        end
    end

endmodule

// File: tb/tb_ex_div_stage.sv
// Self-checking bench for ex_div_stage: directed vector table, streaming,
// back-pressure, mid-divide reset and randomized ops against an arithmetic model.
module tb_ex_div_stage;

    logic        clk_i;
    logic        rst_n_i;
    logic        ctl_id_over_i;
    logic        ctl_ex_allow_in_o;
    logic [31:0] id_pc_i;
    logic [31:0] id_alu_res_i;
    logic [31:0] id_src1_i;
    logic [31:0] id_src2_i;
    logic        id_is_div_i;
    logic [1:0]  id_div_op_i;
    logic [4:0]  id_rd_i;
    logic        id_rf_we_i;
    logic        ctl_mem_allow_in_i;
    logic        ctl_ex_over_o;
    logic [31:0] ex_pc_o;
    logic [31:0] ex_result_o;
    logic [4:0]  ex_rd_o;
    logic        ex_rf_we_o;
    logic        ex_busy_o;

    int total_checks  = 0;
    int passed_checks = 0;

    typedef struct {
        logic        is_div;
        logic [1:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    ex_div_stage #(.DIV_ITERS(32)) dut (
        .clk_i              (clk_i),
        .rst_n_i            (rst_n_i),
        .ctl_id_over_i      (ctl_id_over_i),
        .ctl_ex_allow_in_o  (ctl_ex_allow_in_o),
        .id_pc_i            (id_pc_i),
        .id_alu_res_i       (id_alu_res_i),
        .id_src1_i          (id_src1_i),
        .id_src2_i          (id_src2_i),
        .id_is_div_i        (id_is_div_i),
        .id_div_op_i        (id_div_op_i),
        .id_rd_i            (id_rd_i),
        .id_rf_we_i         (id_rf_we_i),
        .ctl_mem_allow_in_i (ctl_mem_allow_in_i),
        .ctl_ex_over_o      (ctl_ex_over_o),
        .ex_pc_o            (ex_pc_o),
        .ex_result_o        (ex_result_o),
        .ex_rd_o            (ex_rd_o),
        .ex_rf_we_o         (ex_rf_we_o),
        .ex_busy_o          (ex_busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Arithmetic reference: 64-bit division truncating toward zero, which
    // also covers the -2^31 / -1 case without overflow.
    function automatic logic [31:0] ref_model(input logic is_div, input logic [1:0] op,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] alu);
        longint sa, sb, q, r;
        if (!is_div) return alu;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q = sa / sb;
        r = sa % sb;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where ex_over is first seen.
    task automatic applyStimulus(input vec_t v);
        int lat, low_cnt, busy_cnt;
        checkOutput("allow_in_before_op", 32'(ctl_ex_allow_in_o), 32'd1);
        ctl_id_over_i = 1'b1;
        id_is_div_i   = v.is_div;
        id_div_op_i   = v.op;
        id_src1_i     = v.s1;
        id_src2_i     = v.s2;
        id_alu_res_i  = v.alu;
        id_pc_i       = v.pc;
        id_rd_i       = v.rd;
        id_rf_we_i    = v.we;
        @(posedge clk_i);
        @(negedge clk_i);
        ctl_id_over_i = 1'b0;
        id_src1_i     = $urandom;
        id_src2_i     = $urandom;
        id_alu_res_i  = $urandom;
        id_pc_i       = $urandom;
        lat      = 1;
        low_cnt  = 0;
        busy_cnt = 0;
        while (!ctl_ex_over_o && lat < 40) begin
            if (!ctl_ex_allow_in_o) low_cnt++;
            if (ex_busy_o) busy_cnt++;
            @(posedge clk_i);
            @(negedge clk_i);
            lat++;
        end
        checkOutput("over_latency", 32'(lat), 32'(v.exp_lat));
        checkOutput("allow_in_low_cycles", 32'(low_cnt), 32'(v.exp_lat - 1));
        checkOutput("busy_cycles", 32'(busy_cnt), 32'(v.exp_lat - 1));
        checkOutput("result", ex_result_o, v.exp_res);
        checkOutput("pc", ex_pc_o, v.pc);
        checkOutput("rd", 32'(ex_rd_o), 32'(v.rd));
        checkOutput("rf_we", 32'(ex_rf_we_o), 32'(v.we));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation timed out");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t tbl[11];
        vec_t v;
        logic [31:0] hold_res, hold_pc, new_alu, new_pc;
        int stale;

        tbl[0]  = '{1'b0, 2'b00, 32'h0, 32'h0, 32'h1234_5678, 32'h1C00_0000, 5'd5, 1'b1, 32'h1234_5678, 1};
        tbl[1]  = '{1'b0, 2'b11, 32'h5, 32'h0, 32'hCAFE_0001, 32'h1C00_0004, 5'd9, 1'b0, 32'hCAFE_0001, 1};
        tbl[2]  = '{1'b1, 2'b00, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h1C00_0008, 5'd1, 1'b1, 32'hFFFF_FFFD, 33};
        tbl[3]  = '{1'b1, 2'b10, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h1C00_000C, 5'd2, 1'b1, 32'hFFFF_FFFF, 33};
        tbl[4]  = '{1'b1, 2'b01, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h1C00_0010, 5'd3, 1'b1, 32'h7FFF_FFFC, 33};
        tbl[5]  = '{1'b1, 2'b01, 32'd100, 32'h0, 32'h0, 32'h1C00_0014, 5'd4, 1'b1, 32'hFFFF_FFFF, 1};
        tbl[6]  = '{1'b1, 2'b10, 32'd100, 32'h0, 32'h0, 32'h1C00_0018, 5'd6, 1'b1, 32'd100, 1};
        tbl[7]  = '{1'b1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1C00_001C, 5'd7, 1'b1, 32'h8000_0000, 33};
        tbl[8]  = '{1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1C00_0020, 5'd8, 1'b1, 32'h0, 33};
        tbl[9]  = '{1'b1, 2'b11, 32'd100, 32'd7, 32'h0, 32'h1C00_0024, 5'd10, 1'b1, 32'd2, 33};
        tbl[10] = '{1'b1, 2'b00, 32'd7, 32'hFFFF_FFFE, 32'h0, 32'h1C00_0028, 5'd11, 1'b0, 32'hFFFF_FFFD, 33};

        rst_n_i            = 1'b1;
        ctl_id_over_i      = 1'b0;
        ctl_mem_allow_in_i = 1'b1;
        id_pc_i            = '0;
        id_alu_res_i       = '0;
        id_src1_i          = '0;
        id_src2_i          = '0;
        id_is_div_i        = 1'b0;
        id_div_op_i        = '0;
        id_rd_i            = '0;
        id_rf_we_i         = 1'b0;
        #1 rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset_over", 32'(ctl_ex_over_o), 32'd0);
        checkOutput("reset_busy", 32'(ex_busy_o), 32'd0);
        checkOutput("reset_pc", ex_pc_o, 32'd0);
        checkOutput("reset_result", ex_result_o, 32'd0);
        checkOutput("reset_rd_we", {26'd0, ex_rd_o, ex_rf_we_o}, 32'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        $display("[TB] directed vector table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i]);
        end

        $display("[TB] streaming pass-through");
        for (int i = 0; i < 4; i++) begin
            checkOutput("stream_allow_in", 32'(ctl_ex_allow_in_o), 32'd1);
            new_alu       = $urandom;
            ctl_id_over_i = 1'b1;
            id_is_div_i   = 1'b0;
            id_alu_res_i  = new_alu;
            id_pc_i       = 32'h2000_0000 + 32'(i * 4);
            @(posedge clk_i);
            @(negedge clk_i);
            checkOutput("stream_over", 32'(ctl_ex_over_o), 32'd1);
            checkOutput("stream_result", ex_result_o, new_alu);
        end
        ctl_id_over_i = 1'b0;
        @(negedge clk_i);

        $display("[TB] back-pressure");
        ctl_mem_allow_in_i = 1'b0;
        hold_res      = 32'hA5A5_0001;
        hold_pc       = 32'h3000_0000;
        ctl_id_over_i = 1'b1;
        id_is_div_i   = 1'b0;
        id_alu_res_i  = hold_res;
        id_pc_i       = hold_pc;
        @(posedge clk_i);
        @(negedge clk_i);
        new_alu      = 32'h5A5A_0002;
        new_pc       = 32'h3000_0004;
        id_alu_res_i = new_alu;
        id_pc_i      = new_pc;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_over", 32'(ctl_ex_over_o), 32'd1);
            checkOutput("bp_allow_in", 32'(ctl_ex_allow_in_o), 32'd0);
            checkOutput("bp_result_hold", ex_result_o, hold_res);
            checkOutput("bp_pc_hold", ex_pc_o, hold_pc);
            @(posedge clk_i);
            @(negedge clk_i);
        end
        ctl_mem_allow_in_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("bp_release_over", 32'(ctl_ex_over_o), 32'd1);
        checkOutput("bp_release_result", ex_result_o, new_alu);
        checkOutput("bp_release_pc", ex_pc_o, new_pc);
        ctl_id_over_i = 1'b0;
        @(negedge clk_i);

        $display("[TB] reset during divide");
        ctl_id_over_i = 1'b1;
        id_is_div_i   = 1'b1;
        id_div_op_i   = 2'b00;
        id_src1_i     = 32'd1000;
        id_src2_i     = 32'd3;
        id_pc_i       = 32'h4000_0000;
        id_rd_i       = 5'd12;
        id_rf_we_i    = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        ctl_id_over_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(ex_busy_o), 32'd0);
        checkOutput("abort_over", 32'(ctl_ex_over_o), 32'd0);
        checkOutput("abort_allow_in", 32'(ctl_ex_allow_in_o), 32'd1);
        checkOutput("abort_pc", ex_pc_o, 32'd0);
        checkOutput("abort_result", ex_result_o, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        v = '{1'b0, 2'b00, 32'h0, 32'h0, 32'h0BAD_F00D, 32'h4000_0010, 5'd13, 1'b1, 32'h0BAD_F00D, 1};
        applyStimulus(v);
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (ctl_ex_over_o) stale++;
        end
        checkOutput("no_stale_result", 32'(stale), 32'd0);

        $display("[TB] randomized ops");
        for (int i = 0; i < 40; i++) begin
            v.is_div = ($urandom_range(0, 3) != 0);
            v.op     = 2'($urandom_range(0, 3));
            v.s1     = $urandom;
            case ($urandom_range(0, 4))
                0:       v.s2 = 32'd0;
                1:       v.s2 = 32'($urandom_range(1, 15));
                2:       v.s2 = 32'hFFFF_FFFF;
                3:       v.s2 = $urandom;
                default: v.s2 = -32'($urandom_range(1, 100));
            endcase
            if ($urandom_range(0, 3) == 0) v.s1 = 32'($urandom_range(0, 50));
            v.alu     = $urandom;
            v.pc      = $urandom;
            v.rd      = 5'($urandom_range(0, 31));
            v.we      = 1'($urandom_range(0, 1));
            v.exp_res = ref_model(v.is_div, v.op, v.s1, v.s2, v.alu);
            v.exp_lat = (v.is_div && v.s2 != 32'd0) ? 33 : 1;
            applyStimulus(v);
        end
        @(negedge clk_i);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
